hack_rom_loader: RTL

UART bootloader that writes a new Hack program into instruction ROM while the CPU is held in reset. It consumes the byte stream from the UART receiver, checks framing and a checksum, and drives word writes into the ROM's write port. On success it releases the CPU, which restarts at PC 0. It sits between the UART receive path and the ROM, alongside the CPU reset logic in the top level.

---
 rtl/hack_rom_loader_if.sv | 25 ++
 rtl/hack_rom_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader_if.sv
// Byte-stream input from the UART receiver and word-write port into instruction ROM.
// The loader is the master of the ROM write port and consumes the receive strobe.
interface hack_rom_loader_if;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        WR_EN;
    logic [15:0] WR_ADDR;
    logic [15:0] WR_DATA;

    modport master (
        input  RX_DATA,
        input  RX_VALID,
        output WR_EN,
        output WR_ADDR,
        output WR_DATA
    );

    modport slave (
        output RX_DATA,
        output RX_VALID,
        input  WR_EN,
        input  WR_ADDR,
        input  WR_DATA
    );
endinterface

// File: rtl/hack_rom_loader.sv
// UART bootloader: parses SYNC/COUNT/words/CHECKSUM frames and writes Hack words into ROM
// while holding the CPU in reset until a load completes with a good checksum.
module hack_rom_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_WORDS      = 32768,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               CLK_100MHz,
    input  logic               RESET,
    hack_rom_loader_if.master  bus,
    output logic               CPU_HOLD,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERROR,
    output logic [15:0]        LOADED_WORDS
);
    localparam int          TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t             state_r, state_s;
    logic [TMO_W-1:0]   tmo_r;
    logic [7:0]         sum_r, cnt_hi_r, data_hi_r;
    logic [15:0]        count_r, word_idx_r, loaded_r;
    logic               wr_en_r, cpu_hold_r, busy_r, done_r, error_r;
    logic [15:0]        wr_addr_r, wr_data_r;

    logic               sync_s, tmo_hit_s, accept_s;
    logic [15:0]        count_s, word_s, idx_inc_s;
    logic [7:0]         sum_add_s;
    logic               wr_en_s, cpu_hold_s, busy_s, done_s, error_s;
    logic [15:0]        wr_addr_s, wr_data_s;

    function automatic logic in_frame(input state_t s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CHECK);
    endfunction

    assign sync_s    = bus.RX_VALID && (bus.RX_DATA == SYNC_BYTE);
    assign tmo_hit_s = in_frame(state_r) && (tmo_r == TMO_W'(TIMEOUT_CYCLES));
    // An expiring timeout wins over a byte arriving in the same cycle.
    assign accept_s  = bus.RX_VALID && !tmo_hit_s;
    assign count_s   = {cnt_hi_r, bus.RX_DATA};
    assign word_s    = {data_hi_r, bus.RX_DATA};
    assign idx_inc_s = word_idx_r + 16'd1;
    assign sum_add_s = sum_r + bus.RX_DATA;

    // State register
    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        if (tmo_hit_s) begin
            state_s = S_ERR;
        end else begin
            case (state_r)
                S_IDLE, S_ERR: state_s = sync_s ? S_CNT_HI : state_r;
                S_CNT_HI:      state_s = accept_s ? S_CNT_LO : S_CNT_HI;
                S_CNT_LO: begin
                    if (!accept_s) begin
                        state_s = S_CNT_LO;
                    end else if ({1'b0, count_s} > MAX_WORDS_W) begin
                        state_s = S_ERR;
                    end else if (count_s == 16'd0) begin
                        state_s = S_CHECK;
                    end else begin
                        state_s = S_DATA_HI;
                    end
                end
                S_DATA_HI:     state_s = accept_s ? S_DATA_LO : S_DATA_HI;
                S_DATA_LO: begin
                    if (!accept_s) begin
                        state_s = S_DATA_LO;
                    end else if (idx_inc_s == count_r) begin
                        state_s = S_CHECK;
                    end else begin
                        state_s = S_DATA_HI;
                    end
                end
                S_CHECK: begin
                    if (!accept_s) begin
                        state_s = S_CHECK;
                    end else if (sum_add_s == 8'h00) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_ERR;
                    end
                end
                S_DONE:        state_s = S_IDLE;
                default:       state_s = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so registered outputs line up with it
    always_comb begin
        wr_en_s    = (state_r == S_DATA_LO) && accept_s;
        wr_addr_s  = wr_en_s ? word_idx_r : wr_addr_r;
        wr_data_s  = wr_en_s ? word_s : wr_data_r;
        cpu_hold_s = in_frame(state_s) || (state_s == S_ERR);
        busy_s     = in_frame(state_s);
        done_s     = (state_s == S_DONE);
        error_s    = (state_s == S_ERR);
    end

    // Frame datapath, timeout counter and output registers
    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            tmo_r      <= '0;
            sum_r      <= 8'h00;
            cnt_hi_r   <= 8'h00;
            data_hi_r  <= 8'h00;
            count_r    <= 16'd0;
            word_idx_r <= 16'd0;
            loaded_r   <= 16'd0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 16'd0;
            wr_data_r  <= 16'd0;
            cpu_hold_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            tmo_r      <= (in_frame(state_s) && !bus.RX_VALID) ? tmo_r + TMO_W'(1) : '0;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            cpu_hold_r <= cpu_hold_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
            case (state_r)
                S_IDLE, S_ERR: begin
                    if (sync_s) begin
                        sum_r      <= 8'h00;
                        word_idx_r <= 16'd0;
                        loaded_r   <= 16'd0;
                    end
                end
                S_CNT_HI: begin
                    if (accept_s) begin
                        cnt_hi_r <= bus.RX_DATA;
                        sum_r    <= sum_add_s;
                    end
                end
                S_CNT_LO: begin
                    if (accept_s) begin
                        count_r <= count_s;
                        sum_r   <= sum_add_s;
                    end
                end
                S_DATA_HI: begin
                    if (accept_s) begin
                        data_hi_r <= bus.RX_DATA;
                        sum_r     <= sum_add_s;
                    end
                end
                S_DATA_LO: begin
                    if (accept_s) begin
                        word_idx_r <= idx_inc_s;
                        loaded_r   <= loaded_r + 16'd1;
                        sum_r      <= sum_add_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.WR_EN     = wr_en_r;
    assign bus.WR_ADDR   = wr_addr_r;
    assign bus.WR_DATA   = wr_data_r;
    assign CPU_HOLD      = cpu_hold_r;
    assign BUSY          = busy_r;
    assign DONE          = done_r;
    assign ERROR         = error_r;
    assign LOADED_WORDS  = loaded_r;
endmodule
